zjh_seg_scan: RTL and testbench

//  Downstream display stage for the mod-14 counter (Q3..Q0 = 0..13, carry C high while count = 13).

---
 rtl/zjh_seg_pkg.sv | 17 +
 rtl/zjh_seg_decode.sv | 13 +
 rtl/zjh_seg_scan.sv | 125 ++++++++++++
 tb/tb_zjh_seg_scan.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/zjh_seg_pkg.sv
// Shared types and segment patterns for the 4-digit roll/count display.
package zjh_seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;

    typedef logic [3:0] bcd_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; hex A-F included so any nibble decodes
    localparam logic [SEG_W-1:0] SEG_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/zjh_seg_decode.sv
// Combinational nibble to active-low 7-segment pattern.
module zjh_seg_decode
    import zjh_seg_pkg::*;
(
    input  bcd_t             digit,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_LUT[digit];
    end

endmodule

// File: rtl/zjh_seg_scan.sv
// Roll counter and 4-digit multiplexed display for the mod-14 counter stage.
// Define ZJH_SEG_BLANK_EN to blank the leading zero of the roll and count pairs.
module zjh_seg_scan
    import zjh_seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned ROLL_MAX = 99
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic [3:0]       Q,
    input  logic             C,
    input  logic             CLR_ROLL,
    output logic [7:0]       ROLL,
    output logic [3:0]       AN,
    output logic [SEG_W-1:0] SEG,
    output logic             DP
);

    localparam int unsigned DIV_W        = $clog2(SCAN_DIV);
    localparam logic [7:0]  ROLL_MAX_BCD = {4'(ROLL_MAX / 10), 4'(ROLL_MAX % 10)};

    logic             c_d_q,  c_d_d;
    logic [7:0]       roll_q, roll_d;
    bcd_t             q_r_q,  q_r_d;
    logic [DIV_W-1:0] div_q,  div_d;
    logic [1:0]       idx_q,  idx_d;
    logic [3:0]       an_q,   an_d;
    logic [SEG_W-1:0] seg_q,  seg_d;
    logic             dp_q,   dp_d;

    logic             evt;
    logic             cnt_tens;
    bcd_t             cnt_units;
    bcd_t             digit;
    logic             blank;
    logic [SEG_W-1:0] seg_c;

    // Carry edge detect and BCD roll counter; clear wins over a coincident event
    always_comb begin
        c_d_d  = C;
        evt    = C & ~c_d_q;
        roll_d = roll_q;
        if (CLR_ROLL) begin
            roll_d = 8'h00;
        end else if (evt) begin
            if (roll_q == ROLL_MAX_BCD)
                roll_d = 8'h00;
            else if (roll_q[3:0] == 4'd9)
                roll_d = {roll_q[7:4] + 4'd1, 4'd0};
            else
                roll_d = {roll_q[7:4], roll_q[3:0] + 4'd1};
        end
    end

    // Scan divider and digit index
    always_comb begin
        q_r_d = Q;
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Digit select for the current scan position
    always_comb begin
        cnt_tens  = (q_r_q >= 4'd10);
        cnt_units = cnt_tens ? (q_r_q - 4'd10) : q_r_q;
        digit     = cnt_units;
        case (idx_q)
            2'd0:    digit = cnt_units;
            2'd1:    digit = {3'b000, cnt_tens};
            2'd2:    digit = roll_q[3:0];
            default: digit = roll_q[7:4];
        endcase
`ifdef ZJH_SEG_BLANK_EN
        blank = ((idx_q == 2'd3) && (roll_q[7:4] == 4'd0)) ||
                ((idx_q == 2'd1) && !cnt_tens);
`else
        blank = 1'b0;
`endif
    end

    zjh_seg_decode u_decode (
        .digit (digit),
        .seg_c (seg_c)
    );

    // Registered display drive, one cycle behind the scan state
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : seg_c;
        dp_d  = (idx_q != 2'd2);
    end

    always_ff @(posedge Clk) begin
        if (MR) begin
            c_d_q  <= 1'b0;
            roll_q <= 8'h00;
            q_r_q  <= '0;
            div_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            c_d_q  <= c_d_d;
            roll_q <= roll_d;
            q_r_q  <= q_r_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign ROLL = roll_q;
    assign AN   = an_q;
    assign SEG  = seg_q;
    assign DP   = dp_q;

endmodule

// File: tb/tb_zjh_seg_scan.sv
// Directed self-checking bench for zjh_seg_scan (SCAN_DIV=4, ROLL_MAX=99).
module tb_zjh_seg_scan;

    logic       clk;
    logic       mr;
    logic [3:0] q;
    logic       c;
    logic       clr_roll;
    logic [7:0] roll;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp;
    int n_bad;

    zjh_seg_scan #(.SCAN_DIV(4), .ROLL_MAX(99)) dut (
        .Clk      (clk),
        .MR       (mr),
        .Q        (q),
        .C        (c),
        .CLR_ROLL (clr_roll),
        .ROLL     (roll),
        .AN       (an),
        .SEG      (seg),
        .DP       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int gap);
        c = 1'b1;
        tick();
        c = 1'b0;
        ticks(gap);
    endtask

    task automatic clear_roll();
        clr_roll = 1'b1;
        tick();
        clr_roll = 1'b0;
        tick();
    endtask

    // Advance to the first cycle where AN switches from 0111 to 1110
    task automatic sync_scan(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            prev = an;
            tick();
            if (prev == 4'b0111 && an == 4'b1110) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        mr = 1'b1; c = 1'b1; q = 4'd13; clr_roll = 1'b0;
        ticks(3);
        n_cmp++; if (roll !== 8'h00) begin n_bad++; $display("FAIL reset_roll got=%h exp=00", roll); end
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        mr = 1'b0; c = 1'b0;
        tick();
        // q_r is still the reset value on the first scanned digit
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL release_an got=%b exp=1110", an); end
        n_cmp++; if (seg !== 7'h40) begin n_bad++; $display("FAIL release_seg got=%h exp=40", seg); end
        tick();
        n_cmp++; if (seg !== 7'h30) begin n_bad++; $display("FAIL release_seg3 got=%h exp=30", seg); end
        ticks(4);
        n_cmp++; if (roll !== 8'h00) begin n_bad++; $display("FAIL release_noinc got=%h exp=00", roll); end
    endtask

    task automatic test_roll_count();
        for (int i = 0; i < 14; i++) pulse(13);
        n_cmp++; if (roll !== 8'h14) begin n_bad++; $display("FAIL roll14 got=%h exp=14", roll); end
        c = 1'b1;
        ticks(5);
        c = 1'b0;
        ticks(2);
        n_cmp++; if (roll !== 8'h15) begin n_bad++; $display("FAIL roll_held got=%h exp=15", roll); end
    endtask

    task automatic test_roll_wrap();
        clear_roll();
        n_cmp++; if (roll !== 8'h00) begin n_bad++; $display("FAIL clr got=%h exp=00", roll); end
        for (int i = 0; i < 99; i++) pulse(1);
        n_cmp++; if (roll !== 8'h99) begin n_bad++; $display("FAIL roll99 got=%h exp=99", roll); end
        c = 1'b1;
        tick();
        c = 1'b0;
        n_cmp++; if (roll !== 8'h00) begin n_bad++; $display("FAIL wrap got=%h exp=00", roll); end
        tick();
        pulse(1);
        n_cmp++; if (roll !== 8'h01) begin n_bad++; $display("FAIL after_wrap got=%h exp=01", roll); end
        c = 1'b1; clr_roll = 1'b1;
        tick();
        c = 1'b0; clr_roll = 1'b0;
        tick();
        n_cmp++; if (roll !== 8'h00) begin n_bad++; $display("FAIL clr_vs_evt got=%h exp=00", roll); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        bit ok;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h30, 7'h79, 7'h78, 7'h30};
        clear_roll();
        for (int i = 0; i < 37; i++) pulse(1);
        q = 4'd13;
        n_cmp++; if (roll !== 8'h37) begin n_bad++; $display("FAIL roll37 got=%h exp=37", roll); end
        sync_scan(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL scan_sync got=timeout exp=an_rollover"); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (an !== exp_an[i/4] || seg !== exp_seg[i/4] || dp !== (i/4 != 2)) begin
                n_bad++;
                $display("FAIL scan[%0d] got=%b/%h/%b exp=%b/%h/%b", i, an, seg, dp,
                         exp_an[i/4], exp_seg[i/4], (i/4 != 2));
            end
            tick();
        end
    endtask

    task automatic test_blank();
        logic [6:0] exp_seg [4];
        bit ok;
`ifdef ZJH_SEG_BLANK_EN
        exp_seg = '{7'h78, 7'h7F, 7'h12, 7'h7F};
`else
        exp_seg = '{7'h78, 7'h40, 7'h12, 7'h40};
`endif
        clear_roll();
        for (int i = 0; i < 5; i++) pulse(1);
        q = 4'd7;
        sync_scan(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL blank_sync got=timeout exp=an_rollover"); end
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (seg !== exp_seg[d] || dp !== (d != 2)) begin
                n_bad++;
                $display("FAIL blank_digit%0d got=%h/%b exp=%h/%b", d, seg, dp, exp_seg[d], (d != 2));
            end
            ticks(4);
        end
    endtask

    task automatic test_mid_scan_reset();
        mr = 1'b1;
        tick();
        mr = 1'b0;
        ticks(11);
        n_cmp++; if (an !== 4'b1011) begin n_bad++; $display("FAIL pre_mr_an got=%b exp=1011", an); end
        mr = 1'b1;
        tick();
        mr = 1'b0;
        n_cmp++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || roll !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_mr got=%b/%h/%b/%h exp=1111/7f/1/00", an, seg, dp, roll);
        end
        tick();
        n_cmp++; if (an !== 4'b1110 || seg !== 7'h40) begin n_bad++; $display("FAIL restart0 got=%b/%h exp=1110/40", an, seg); end
        ticks(3);
        n_cmp++; if (an !== 4'b1110 || seg !== 7'h78) begin n_bad++; $display("FAIL restart3 got=%b/%h exp=1110/78", an, seg); end
        tick();
        n_cmp++; if (an !== 4'b1101) begin n_bad++; $display("FAIL restart4 got=%b exp=1101", an); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mr = 1'b1; q = 4'd0; c = 1'b0; clr_roll = 1'b0;
        test_reset();
        test_roll_count();
        test_roll_wrap();
        test_scan();
        test_blank();
        test_mid_scan_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
